// File: rtl/pudding_dac_sequencer.sv
// pudding_dac_sequencer
// Serial-programmed controller for the two current-steering DACs:
// the state DAC (L) and the daisychain DAC (H). A 16-bit frame is shifted
// in MSB first and committed with latch. The sequencer then updates the
// selected DAC's thermometer ON vector, enable mask and code. When the
// enable mask changes, the enables are dropped for a guard window first
// (break-before-make). In ramp mode the code steps by one every 4^rate
// cycles.
//
// Frame layout: [15] ch (0=L, 1=H), [14] mode (0=direct, 1=ramp),
//               [13:10] enable mask, [9:8] rate, [7:0] code (saturates to N_UNITS)
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   sdi        serial data in, MSB first
//   shift      shift sdi into the frame register this cycle
//   latch      commit the frame register this cycle (has priority over shift)
//   sdo        frame register bit 15, for daisy readback
//   busy       high while the sequencer is not idle
//   frame_err  one-cycle pulse after a rejected latch
//   on_l/on_h  thermometer ON vectors for DAC L / DAC H
//   en_l/en_h  enable masks for DAC L / DAC H
//   code_l/h   currently applied codes for DAC L / DAC H
module pudding_dac_sequencer #(
  parameter int N_UNITS      = 128,
  parameter int N_EN         = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sdi,
  input  logic               shift,
  input  logic               latch,
  output logic               sdo,
  output logic               busy,
  output logic               frame_err,
  output logic [N_UNITS-1:0] on_l,
  output logic [N_EN-1:0]    en_l,
  output logic [N_UNITS-1:0] on_h,
  output logic [N_EN-1:0]    en_h,
  output logic [7:0]         code_l,
  output logic [7:0]         code_h
);

  typedef enum logic [1:0] {IDLE, GUARD, APPLY, RAMP} state_t;

  localparam logic [7:0] MAX_CODE   = 8'(N_UNITS);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

  state_t          state, state_next;
  logic [15:0]     sr;
  logic [4:0]      bit_cnt;

  // Fields of the frame being executed, captured at the accepted latch
  logic            sel_ch;
  logic            sel_ramp;
  logic [N_EN-1:0] sel_mask;
  logic [1:0]      sel_rate;
  logic [7:0]      target;

  logic [7:0]      guard_cnt;
  logic [5:0]      tick;

  logic            accept, reject;
  logic [N_EN-1:0] frame_mask;
  logic [7:0]      frame_code;
  logic            need_guard;
  logic [7:0]      cur_code, step_code;
  logic [5:0]      tick_last;
  logic            step_now;

  function automatic logic [N_UNITS-1:0] therm(input logic [7:0] c);
    logic [N_UNITS-1:0] v;
    v = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      v[i] = (i < int'(c));
    end
    return v;
  endfunction

  assign sdo  = sr[15];
  assign busy = (state != IDLE);

  // Frame decode and ramp step arithmetic. The guard decision compares the
  // incoming mask against the enable mask currently driven on the addressed DAC.
  always_comb begin
    frame_mask = N_EN'(sr[13:10]);
    frame_code = (sr[7:0] > MAX_CODE) ? MAX_CODE : sr[7:0];
    need_guard = (frame_mask != (sr[15] ? en_h : en_l));
    accept     = latch && (bit_cnt == 5'd16) && (state == IDLE);
    reject     = latch && !accept;
    cur_code   = sel_ch ? code_h : code_l;
    step_code  = (cur_code < target) ? cur_code + 8'd1 : cur_code - 8'd1;
    case (sel_rate)
      2'd0:    tick_last = 6'd0;
      2'd1:    tick_last = 6'd3;
      2'd2:    tick_last = 6'd15;
      default: tick_last = 6'd63;
    endcase
    step_now = (state == RAMP) && (cur_code != target) && (tick == tick_last);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = need_guard ? GUARD : (sr[14] ? RAMP : APPLY);
      GUARD:   if (guard_cnt == GUARD_LAST) state_next = sel_ramp ? RAMP : APPLY;
      APPLY:   state_next = IDLE;
      RAMP:    if (cur_code == target) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus all output registers. Only the channel captured in
  // sel_ch is ever written after a frame is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
      sel_ch    <= 1'b0;
      sel_ramp  <= 1'b0;
      sel_mask  <= '0;
      sel_rate  <= '0;
      target    <= '0;
      guard_cnt <= '0;
      tick      <= '0;
      on_l      <= '0;
      on_h      <= '0;
      en_l      <= '0;
      en_h      <= '0;
      code_l    <= '0;
      code_h    <= '0;
    end else begin
      state     <= state_next;
      frame_err <= reject;

      if (latch) begin
        bit_cnt <= '0;
      end else if (shift) begin
        sr <= {sr[14:0], sdi};
        if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
      end

      if (accept) begin
        sel_ch    <= sr[15];
        sel_ramp  <= sr[14];
        sel_mask  <= frame_mask;
        sel_rate  <= sr[9:8];
        target    <= frame_code;
        guard_cnt <= '0;
        tick      <= '0;
        // Break before make: drop the enables before any new mask is driven
        if (need_guard) begin
          if (sr[15]) en_h <= '0;
          else        en_l <= '0;
        end
      end

      case (state)
        GUARD: begin
          guard_cnt <= guard_cnt + 8'd1;
          // A ramp starts with the new enables already applied
          if ((guard_cnt == GUARD_LAST) && sel_ramp) begin
            if (sel_ch) en_h <= sel_mask;
            else        en_l <= sel_mask;
          end
        end
        APPLY: begin
          if (sel_ch) begin
            code_h <= target;
            on_h   <= therm(target);
            en_h   <= sel_mask;
          end else begin
            code_l <= target;
            on_l   <= therm(target);
            en_l   <= sel_mask;
          end
        end
        RAMP: begin
          if (cur_code != target) begin
            if (step_now) begin
              tick <= '0;
              if (sel_ch) begin
                code_h <= step_code;
                on_h   <= therm(step_code);
              end else begin
                code_l <= step_code;
                on_l   <= therm(step_code);
              end
            end else begin
              tick <= tick + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pudding_dac_sequencer.sv
// Testbench for pudding_dac_sequencer. It drives directed command frames and
// keeps a behavioural model that predicts every output on every cycle. Each
// accepted frame is modelled as a timeline: a guard window, then an apply
// or a ramp with one step per 4^rate cycles. Literal checks pin the timing
// of the main cases.
module tb_pudding_dac_sequencer;

  localparam int GUARD = 2;

  logic         clk = 1'b0;
  logic         rst_n, sdi, shift, latch;
  logic         sdo, busy, frame_err;
  logic [127:0] on_l, on_h;
  logic [3:0]   en_l, en_h;
  logic [7:0]   code_l, code_h;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pudding_dac_sequencer #(
    .N_UNITS(128),
    .N_EN(4),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sdi(sdi),
    .shift(shift),
    .latch(latch),
    .sdo(sdo),
    .busy(busy),
    .frame_err(frame_err),
    .on_l(on_l),
    .en_l(en_l),
    .on_h(on_h),
    .en_h(en_h),
    .code_l(code_l),
    .code_h(code_h)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] m_therm(input int c);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < c; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Model state: frame register, bit count and the committed per-channel values
  logic [15:0] m_sr;
  int          m_cnt;
  bit          m_ferr, m_busy, mvalid;
  int          base_code [2];
  logic [3:0]  base_en   [2];
  int          ecode     [2];
  logic [3:0]  een       [2];

  // The frame currently being executed, described by its parameters and latch time
  bit          t_act, t_ch, t_ramp, t_g;
  logic [3:0]  t_mask;
  int          t_start, t_tgt, t_per, t_t0;
  int          edge_idx = 0;

  initial mvalid = 0;

  // Model update on every rising edge, then compare against the DUT 1 time unit later
  always @(posedge clk) begin
    int c, e, n, k, last;
    edge_idx++;
    if (!rst_n) begin
      m_sr = '0; m_cnt = 0; m_ferr = 0; m_busy = 0; t_act = 0;
      for (int i = 0; i < 2; i++) begin
        base_code[i] = 0; base_en[i] = '0; ecode[i] = 0; een[i] = '0;
      end
      mvalid = 1;
    end else begin
      m_ferr = 0;
      if (latch) begin
        if (m_cnt == 16 && !m_busy) begin
          t_act   = 1;
          t_ch    = m_sr[15];
          t_ramp  = m_sr[14];
          t_mask  = m_sr[13:10];
          t_per   = 1 << (2 * int'(m_sr[9:8]));
          t_tgt   = (m_sr[7:0] > 8'd128) ? 128 : int'(m_sr[7:0]);
          t_start = base_code[t_ch];
          t_g     = (t_mask != base_en[t_ch]);
          t_t0    = edge_idx;
        end else begin
          m_ferr = 1;
        end
        m_cnt = 0;
      end else if (shift) begin
        m_sr = {m_sr[14:0], sdi};
        if (m_cnt < 16) m_cnt++;
      end

      for (int i = 0; i < 2; i++) begin
        ecode[i] = base_code[i];
        een[i]   = base_en[i];
      end
      m_busy = 0;
      if (t_act) begin
        c = edge_idx - t_t0 + 1;
        e = t_g ? GUARD + 1 : 1;
        if (!t_ramp) begin
          m_busy      = (c <= e);
          ecode[t_ch] = (c > e) ? t_tgt : t_start;
          een[t_ch]   = (c > e) ? t_mask : (t_g ? 4'h0 : base_en[t_ch]);
        end else begin
          n      = (t_tgt >= t_start) ? t_tgt - t_start : t_start - t_tgt;
          last   = e + n * t_per;
          m_busy = (c <= last);
          k      = (c >= e) ? (c - e) / t_per : 0;
          if (k > n) k = n;
          ecode[t_ch] = (t_tgt >= t_start) ? t_start + k : t_start - k;
          een[t_ch]   = (t_g && c < e) ? 4'h0 : t_mask;
        end
        if (!m_busy) begin
          base_code[t_ch] = ecode[t_ch];
          base_en[t_ch]   = een[t_ch];
          t_act = 0;
        end
      end
    end

    #1;
    if (mvalid) begin
      checkOutput("sdo", sdo, m_sr[15]);
      checkOutput("busy", busy, m_busy);
      checkOutput("frame_err", frame_err, m_ferr);
      checkOutput("code_l", code_l, ecode[0]);
      checkOutput("en_l", en_l, een[0]);
      checkOutput("on_l", on_l, m_therm(ecode[0]));
      checkOutput("code_h", code_h, ecode[1]);
      checkOutput("en_h", en_h, een[1]);
      checkOutput("on_h", on_h, m_therm(ecode[1]));
    end
  end

  // Shift the low nbits of frame MSB first, then latch; returns at the
  // falling edge of the first cycle after the latch
  task automatic applyStimulus(input logic [15:0] frame, input int nbits, input bit shift_on_latch);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      shift = 1'b1;
      sdi   = frame[i];
    end
    @(negedge clk);
    shift = shift_on_latch;
    sdi   = 1'b1;
    latch = 1'b1;
    @(negedge clk);
    shift = 1'b0;
    latch = 1'b0;
    sdi   = 1'b0;
  endtask

  // Count cycles busy stays high, bounded so a stuck FSM cannot hang the run
  task automatic countBusy(output int nb);
    nb = 0;
    while (busy === 1'b1 && nb < 400) begin
      nb++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Directed scenario sequence
  initial begin
    int nb;
    int w;
    rst_n = 1'b0; sdi = 1'b0; shift = 1'b0; latch = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_code_l", code_l, 0);
    checkOutput("reset_on_h", on_h, 0);
    rst_n = 1'b1;

    // L direct, mask 0011, code 64: mask changes so the guard runs first
    applyStimulus(16'h0F40, 16, 0);
    checkOutput("guard_en_low", en_l, 0);
    countBusy(nb);
    checkOutput("guard_busy_len", nb, 3);
    checkOutput("direct_code_l", code_l, 64);
    checkOutput("direct_en_l", en_l, 4'b0011);
    checkOutput("direct_on_l", on_l, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    checkOutput("h_untouched", code_h, 0);

    // Same mask, code 0xFF saturates to 128, visible two cycles after latch
    applyStimulus(16'h0FFF, 16, 0);
    checkOutput("noguard_busy_c1", busy, 1);
    checkOutput("noguard_old_code", code_l, 64);
    @(negedge clk);
    checkOutput("noguard_busy_c2", busy, 0);
    checkOutput("sat_code_l", code_l, 128);
    checkOutput("sat_on_l", on_l, {128{1'b1}});

    // Latch after only 15 shifts is rejected
    applyStimulus(16'h0123, 15, 0);
    checkOutput("short_frame_err", frame_err, 1);
    @(negedge clk);
    checkOutput("short_err_pulse", frame_err, 0);
    checkOutput("short_code_l", code_l, 128);

    // L ramp down 128->126 at rate 2 with a mask change; latch while busy is rejected
    applyStimulus(16'h467E, 16, 0);
    applyStimulus(16'h0000, 16, 0);
    checkOutput("busy_frame_err", frame_err, 1);
    countBusy(nb);
    checkOutput("ramp_down_code_l", code_l, 126);
    checkOutput("ramp_down_en_l", en_l, 4'b0001);

    // H ramp 0->5 at rate 1, mask unchanged: 21 busy cycles
    applyStimulus(16'hC105, 16, 0);
    countBusy(nb);
    checkOutput("ramp_busy_len", nb, 21);
    checkOutput("ramp_code_h", code_h, 5);
    checkOutput("ramp_on_h", on_h, 128'h1F);

    // H ramp back toward 0; reset when code_h reaches 3
    applyStimulus(16'hC100, 16, 0);
    w = 0;
    while (code_h !== 8'd3 && w < 100) begin
      w++;
      @(negedge clk);
    end
    checkOutput("ramp_reach3", code_h, 3);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_code_h", code_h, 0);
    checkOutput("abort_code_l", code_l, 0);
    checkOutput("abort_en_l", en_l, 0);
    checkOutput("abort_busy", busy, 0);
    rst_n = 1'b1;

    // Ramp whose target equals the current code finishes after one cycle
    applyStimulus(16'hC000, 16, 0);
    countBusy(nb);
    checkOutput("ramp_equal_len", nb, 1);

    // Shift held high on the latch cycle: frame accepted, register not shifted
    applyStimulus(16'h0CC8, 16, 1);
    countBusy(nb);
    checkOutput("shiftlatch_busy_len", nb, 3);
    checkOutput("shiftlatch_code_l", code_l, 128);
    checkOutput("shiftlatch_en_l", en_l, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      shift = 1'b1;
      sdi   = 1'b0;
    end
    @(negedge clk);
    shift = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pudding_dac_sequencer.md
Name: pudding_dac_sequencer

Overview:
Serial-programmed controller for the two 128-unit current-steering DACs: the state DAC (L) and the daisychain DAC (H).
- Accepts 16-bit command frames over a shift/latch pin interface.
- Converts an 8-bit code into a 128-bit thermometer ON vector and a 4-bit enable mask.
- Sequences updates with break-before-make on enable changes, plus an optional ramp mode.
- Outputs feed the inverter-pair drivers ahead of the DAC macros.

Parameters:
N_UNITS, 128, unit cells per DAC (thermometer length)
N_EN, 4, enable groups per DAC
GUARD_CYCLES, 2, cycles the enables are held low before a new mask is applied (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
sdi  in  1  serial data, MSB first
shift  in  1  shift sdi into the frame register this cycle
latch  in  1  commit the frame register this cycle
sdo  out  1  frame register bit 15 (daisy readback)
busy  out  1  high whenever FSM != IDLE
frame_err  out  1  one-cycle pulse on a rejected latch
on_l  out  N_UNITS  thermometer ON vector, DAC L
en_l  out  N_EN  enable mask, DAC L
on_h  out  N_UNITS  thermometer ON vector, DAC H
en_h  out  N_EN  enable mask, DAC H
code_l  out  8  current applied code, DAC L
code_h  out  8  current applied code, DAC H

Behaviour:
- Reset (rst_n=0 at an edge): sr=0, bit count=0, FSM=IDLE, all on/en/code=0, busy=0, frame_err=0, sdo=0. Reset mid-ramp or mid-guard aborts immediately to these values.
- Shift: when shift=1 and latch=0, sr <= {sr[14:0], sdi}; bit count increments, saturating at 16. Shifting is allowed while busy.
- Frame fields: [15] ch (0=L, 1=H); [14] mode (0=direct, 1=ramp); [13:10] en mask; [9:8] rate; [7:0] code.
- Code saturation: a code above 128 saturates to 128.
- Latch has priority: when latch=1, shift is ignored that cycle and bit count resets to 0.
  - Accepted only if count==16 and FSM==IDLE.
  - Otherwise rejected: frame_err pulses high in the next cycle and no state changes.
- FSM states are IDLE, GUARD, APPLY, RAMP. An accepted latch in cycle 0 does the following:
  - If the mask differs from the selected channel's en: go to GUARD and set en_x<=0 (visible cycle 1). Stay GUARD_CYCLES cycles, then go to APPLY if direct, or to RAMP if ramp with en_x<=mask.
  - If the mask is unchanged: go to APPLY (direct) or RAMP (ramp) in cycle 1.
- APPLY (one cycle):
  - code_x<=target, on_x<=therm(target), en_x<=mask.
  - New values are visible the following cycle; FSM returns to IDLE at the same time.
  - Direct, no guard: latch in cycle 0 -> busy in cycle 1 -> new outputs and busy=0 in cycle 2.
- RAMP:
  - A tick counter is cleared on entry. Every 4^rate cycles (1, 4, 16, 64), code_x steps by 1 toward the target and on_x is updated in the same edge.
  - Exits to IDLE on the cycle code_x==target is observed. If already equal on entry, it exits after one cycle.
  - Rate 0, 0->128 takes 128 steps.
- therm(c): on[i]=1 for i<c, else 0. c=0 gives all zeros; c=128 gives all ones.
- Output registers: on/en/code are all registered. The unselected channel never changes.

Test Plan:
- Reset then idle: all outputs 0, busy=0. Shift 16 bits 0x0F40 (L, direct, en=0011, code=0x40) and latch. Expect en_l drops to 0 for 2 cycles, then on_l=64 ones, code_l=64, en_l=4'b0011. DAC H is untouched.
- Same mask, new code 0xFF on L: no guard. code_l=128, on_l all ones, visible 2 cycles after latch.
- Latch after only 15 shifts: frame_err pulses once and outputs are unchanged. A latch while busy also gives frame_err.
- Ramp frame on H, rate=1, from code 0 to 5, mask unchanged: code_h steps every 4 cycles and reaches 5 after 20 RAMP cycles. busy drops the next cycle.
- Assert rst_n=0 mid-ramp at code_h=3: next cycle all outputs are 0 and FSM is IDLE.
- Shift and latch in the same cycle with count==16: the frame is accepted and sr is not shifted. sdo equals sr[15] throughout.
